// File: rtl/id_ex_if.sv
// ID->EX stage bundle: ID_* fields driven by decode, EX_* fields driven by the pipeline register.
interface id_ex_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_W  = 5
);
   logic              ID_valid;
   logic [2:0]        ID_Si;
   logic [DATA_W-1:0] ID_PA;
   logic [DATA_W-1:0] ID_PB;
   logic [11:0]       ID_imm12_I;
   logic [11:0]       ID_imm12_S;
   logic [19:0]       ID_imm20;
   logic [DATA_W-1:0] ID_PC;
   logic [3:0]        ID_ALU_op;
   logic [REG_W-1:0]  ID_rd;
   logic              ID_RF_LE;
   logic              ID_load;
   logic              ID_mem_write;
   logic [1:0]        ID_mem_size;

   logic              EX_valid;
   logic [2:0]        EX_Si;
   logic [DATA_W-1:0] EX_PA;
   logic [DATA_W-1:0] EX_PB;
   logic [11:0]       EX_imm12_I;
   logic [11:0]       EX_imm12_S;
   logic [19:0]       EX_imm20;
   logic [DATA_W-1:0] EX_PC;
   logic [3:0]        EX_ALU_op;
   logic [REG_W-1:0]  EX_rd;
   logic              EX_RF_LE;
   logic              EX_load;
   logic              EX_mem_write;
   logic [1:0]        EX_mem_size;

   modport master (
      output ID_valid, ID_Si, ID_PA, ID_PB, ID_imm12_I, ID_imm12_S, ID_imm20, ID_PC,
             ID_ALU_op, ID_rd, ID_RF_LE, ID_load, ID_mem_write, ID_mem_size,
      input  EX_valid, EX_Si, EX_PA, EX_PB, EX_imm12_I, EX_imm12_S, EX_imm20, EX_PC,
             EX_ALU_op, EX_rd, EX_RF_LE, EX_load, EX_mem_write, EX_mem_size
   );

   modport slave (
      input  ID_valid, ID_Si, ID_PA, ID_PB, ID_imm12_I, ID_imm12_S, ID_imm20, ID_PC,
             ID_ALU_op, ID_rd, ID_RF_LE, ID_load, ID_mem_write, ID_mem_size,
      output EX_valid, EX_Si, EX_PA, EX_PB, EX_imm12_I, EX_imm12_S, EX_imm20, EX_PC,
             EX_ALU_op, EX_rd, EX_RF_LE, EX_load, EX_mem_write, EX_mem_size
   );
endinterface

// File: rtl/id_ex_pipeline_register.sv
// ID->EX pipeline register with stall (hold) and flush (bubble); priority reset > flush > stall.
// Optional saturating stall counter enabled by defining ID_EX_STALL_COUNT_EN.
module id_ex_pipeline_register #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_W  = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush,
`ifdef ID_EX_STALL_COUNT_EN
   id_ex_if.slave      bus,
   output logic [15:0] stall_count
`else
   id_ex_if.slave      bus
`endif
);

   localparam int unsigned BusW = 1 + 3 + 3 * DATA_W + 12 + 12 + 20 + 4 + REG_W + 1 + 1 + 1 + 2;

   logic [BusW-1:0] id_bus;
   logic [BusW-1:0] ex_q;

   // All fields travel as one flat word so hold/bubble behave identically for every field.
   assign id_bus = {bus.ID_valid, bus.ID_Si, bus.ID_PA, bus.ID_PB, bus.ID_imm12_I,
                    bus.ID_imm12_S, bus.ID_imm20, bus.ID_PC, bus.ID_ALU_op, bus.ID_rd,
                    bus.ID_RF_LE, bus.ID_load, bus.ID_mem_write, bus.ID_mem_size};

   assign {bus.EX_valid, bus.EX_Si, bus.EX_PA, bus.EX_PB, bus.EX_imm12_I,
           bus.EX_imm12_S, bus.EX_imm20, bus.EX_PC, bus.EX_ALU_op, bus.EX_rd,
           bus.EX_RF_LE, bus.EX_load, bus.EX_mem_write, bus.EX_mem_size} = ex_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         ex_q <= '0;
      end else if (flush) begin
         ex_q <= '0;
      end else if (!stall) begin
         ex_q <= id_bus;
      end
   end

`ifdef ID_EX_STALL_COUNT_EN
   // Counts only stalls that hold a real instruction; saturates instead of wrapping.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_count <= 16'd0;
      end else if (stall && !flush && ex_q[BusW-1] && (stall_count != 16'hFFFF)) begin
         stall_count <= stall_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_id_ex_pipeline_register.sv
// Randomized + directed bench for id_ex_pipeline_register against a field-level reference model.
// Define ID_EX_STALL_COUNT_EN to also exercise the stall counter.
module tb_id_ex_pipeline_register;

   typedef struct packed {
      logic        valid;
      logic [2:0]  si;
      logic [31:0] pa;
      logic [31:0] pb;
      logic [11:0] imm_i;
      logic [11:0] imm_s;
      logic [19:0] imm20;
      logic [31:0] pc;
      logic [3:0]  alu_op;
      logic [4:0]  rd;
      logic        rf_le;
      logic        load;
      logic        mem_write;
      logic [1:0]  mem_size;
   } fields_t;

   logic    clk = 1'b0;
   logic    reset = 1'b1;
   logic    stall = 1'b0;
   logic    flush = 1'b0;
   fields_t id_f = '0;
   fields_t exp_f = '0;
   fields_t obs_f;
   int      vectors = 0;
   int      miscompares = 0;
   int      exp_cnt = 0;

   always #5 clk = ~clk;

   id_ex_if #(.DATA_W(32), .REG_W(5)) bus_if ();

   assign bus_if.ID_valid     = id_f.valid;
   assign bus_if.ID_Si        = id_f.si;
   assign bus_if.ID_PA        = id_f.pa;
   assign bus_if.ID_PB        = id_f.pb;
   assign bus_if.ID_imm12_I   = id_f.imm_i;
   assign bus_if.ID_imm12_S   = id_f.imm_s;
   assign bus_if.ID_imm20     = id_f.imm20;
   assign bus_if.ID_PC        = id_f.pc;
   assign bus_if.ID_ALU_op    = id_f.alu_op;
   assign bus_if.ID_rd        = id_f.rd;
   assign bus_if.ID_RF_LE     = id_f.rf_le;
   assign bus_if.ID_load      = id_f.load;
   assign bus_if.ID_mem_write = id_f.mem_write;
   assign bus_if.ID_mem_size  = id_f.mem_size;

   assign obs_f = '{valid: bus_if.EX_valid, si: bus_if.EX_Si, pa: bus_if.EX_PA,
                    pb: bus_if.EX_PB, imm_i: bus_if.EX_imm12_I, imm_s: bus_if.EX_imm12_S,
                    imm20: bus_if.EX_imm20, pc: bus_if.EX_PC, alu_op: bus_if.EX_ALU_op,
                    rd: bus_if.EX_rd, rf_le: bus_if.EX_RF_LE, load: bus_if.EX_load,
                    mem_write: bus_if.EX_mem_write, mem_size: bus_if.EX_mem_size};

`ifdef ID_EX_STALL_COUNT_EN
   logic [15:0] stall_count;
   id_ex_pipeline_register #(.DATA_W(32), .REG_W(5)) dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .bus(bus_if.slave), .stall_count(stall_count)
   );
`else
   id_ex_pipeline_register #(.DATA_W(32), .REG_W(5)) dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush), .bus(bus_if.slave)
   );
`endif

   task automatic check(input string tag);
      vectors++;
      assert (obs_f === exp_f) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs_f, exp_f);
      end
`ifdef ID_EX_STALL_COUNT_EN
      vectors++;
      assert (stall_count === 16'(exp_cnt)) else begin
         miscompares++;
         $error("FAIL %s_cnt observed=%h expected=%h", tag, stall_count, 16'(exp_cnt));
      end
`endif
   endtask

   // Reference model: spec rules applied to the whole field set, then one clock edge.
   task automatic step(input logic r, input logic s, input logic f, input string tag);
      reset = r;
      stall = s;
      flush = f;
      if (r) begin
         exp_cnt = 0;
         exp_f   = '0;
      end else begin
         if (s && !f && exp_f.valid && exp_cnt < 65535) exp_cnt++;
         if (f) exp_f = '0;
         else if (!s) exp_f = id_f;
      end
      @(posedge clk);
      #1;
      check(tag);
   endtask

   task automatic rand_fields();
      logic [191:0] raw;
      raw  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      id_f = raw[$bits(fields_t)-1:0];
   endtask

   initial begin
      // 1: reset with all inputs nonzero
      id_f = '1;
      step(1'b1, 1'b0, 1'b0, "reset0");
      step(1'b1, 1'b1, 1'b0, "reset1");

      // 2: directed load, then update
      id_f       = '0;
      id_f.valid = 1'b1;
      id_f.si    = 3'b010;
      id_f.pb    = 32'h0431FFEA;
      id_f.imm_i = 12'hC0C;
      id_f.pc    = 32'hC431FFEA;
      step(1'b0, 1'b0, 1'b0, "load");
      id_f.pa    = 32'h12345678;
      id_f.rd    = 5'd17;
      id_f.rf_le = 1'b1;
      #1;
      check("no_comb_path");
      id_f.pa = 32'h0;
      id_f.rd = 5'd0;
      id_f.rf_le = 1'b0;
      step(1'b0, 1'b0, 1'b0, "load_same");

      // 3: three-cycle stall while PB changes
      id_f.pb = 32'hDEADBEEF;
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, "stall_hold");
      vectors++;
      assert (obs_f.pb === 32'h0431FFEA) else begin
         miscompares++;
         $error("FAIL stall_pb observed=%h expected=%h", obs_f.pb, 32'h0431FFEA);
      end
      step(1'b0, 1'b0, 1'b0, "stall_release");
      vectors++;
      assert (obs_f.pb === 32'hDEADBEEF) else begin
         miscompares++;
         $error("FAIL release_pb observed=%h expected=%h", obs_f.pb, 32'hDEADBEEF);
      end

      // 4: flush beats stall
      step(1'b0, 1'b1, 1'b1, "flush_wins");

      // 5: reset during stall, then resume loading
      rand_fields();
      id_f.valid = 1'b1;
      step(1'b0, 1'b0, 1'b0, "reload");
      step(1'b0, 1'b1, 1'b0, "stall_pre_reset");
      step(1'b1, 1'b1, 1'b0, "reset_mid_stall");
      step(1'b0, 1'b0, 1'b0, "post_reset_load");

      // Random traffic with occasional reset/flush/stall
      for (int i = 0; i < 400; i++) begin
         logic r, s, f;
         rand_fields();
         r = ($urandom_range(31) == 0);
         f = ($urandom_range(7) == 0);
         s = ($urandom_range(3) == 0);
         step(r, s, f, "random");
         rand_fields();
         #1;
         check("random_comb");
      end

`ifdef ID_EX_STALL_COUNT_EN
      // 6: stall counter count, saturation, reset
      step(1'b1, 1'b0, 1'b0, "cnt_reset");
      id_f       = '0;
      id_f.valid = 1'b1;
      step(1'b0, 1'b0, 1'b0, "cnt_load");
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, "cnt_stall");
      vectors++;
      assert (stall_count === 16'd5) else begin
         miscompares++;
         $error("FAIL cnt_five observed=%h expected=%h", stall_count, 16'd5);
      end
      step(1'b0, 1'b1, 1'b1, "cnt_flush");
      step(1'b0, 1'b0, 1'b0, "cnt_reload");
      for (int i = 5; i < 65534; i++) step(1'b0, 1'b1, 1'b0, "cnt_fill");
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, "cnt_sat");
      vectors++;
      assert (stall_count === 16'hFFFF) else begin
         miscompares++;
         $error("FAIL cnt_sat observed=%h expected=%h", stall_count, 16'hFFFF);
      end
      step(1'b1, 1'b0, 1'b0, "cnt_clear");
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
